mul_issue_ctrl: RTL and testbench

MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

---
 rtl/mul_pkg.sv | 52 +++++
 rtl/mul_result_sel.sv | 28 ++
 rtl/mul_issue_ctrl.sv | 134 +++++++++++++
 tb/tb_mul_issue_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_pkg
// Description : Shared op encodings, signedness codes and issue-FSM states
//               for the multiplier issue controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

  // Upstream op encodings; raw codes 5-7 decode to OP_MUL
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_MULW   = 3'd4
  } mul_op_e;

  // Operand signedness codes: bit 1 = multiplicand signed, bit 0 = multiplier signed
  localparam logic [1:0] c_MS_UU = 2'b00;
  localparam logic [1:0] c_MS_SU = 2'b10;
  localparam logic [1:0] c_MS_SS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } mul_state_e;

  // Fold the 3-bit raw op onto the defined encodings
  function automatic mul_op_e decode_op(input logic [2:0] raw);
    case (raw)
      3'd1:    return OP_MULH;
      3'd2:    return OP_MULHSU;
      3'd3:    return OP_MULHU;
      3'd4:    return OP_MULW;
      default: return OP_MUL;
    endcase
  endfunction

  // Signedness presented to the unit; 2'b01 is never produced
  function automatic logic [1:0] signed_code(input mul_op_e op);
    case (op)
      OP_MULHSU: return c_MS_SU;
      OP_MULHU:  return c_MS_UU;
      default:   return c_MS_SS;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_result_sel.sv
`default_nettype none
// ============================================================================
// Module      : mul_result_sel
// Description : Picks the writeback word from the unit's 128-bit product and
//               sign-extends the 32-bit MULW result.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_result_sel
  import mul_pkg::*;
(
  input  mul_op_e     op,
  input  logic [63:0] result_hi,
  input  logic [63:0] result_lo,
  output logic [63:0] data
);

  // High-half ops take result_hi, MULW sign-extends the low word
  always_comb begin
    data = result_lo;
    case (op)
      OP_MULH, OP_MULHSU, OP_MULHU: data = result_hi;
      OP_MULW:                      data = {{32{result_lo[31]}}, result_lo[31:0]};
      default:                      data = result_lo;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul_issue_ctrl
// Description : Accepts one multiply op, issues it to a pipelined multiplier
//               unit, captures the one-cycle result pulse and holds it for a
//               ready/valid writeback. Flush kills the in-flight op.
//               Optional macro MUL_ISSUE_CTRL_ZERO_BYPASS_EN: ops with a zero
//               operand skip the unit and complete with zero the next cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_issue_ctrl
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic [63:0] in_src1,
  input  logic [63:0] in_src2,
  input  logic [4:0]  in_rd,
  input  logic        flush,
  output logic        mul_valid,
  output logic        mulw,
  output logic [1:0]  mul_signed,
  output logic [63:0] multiplicand,
  output logic [63:0] multiplier,
  input  logic        mul_out_ready,
  input  logic        mul_out_valid,
  input  logic [63:0] result_hi,
  input  logic [63:0] result_lo,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [63:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        busy
);

  mul_state_e  r_state;
  mul_state_e  w_state_nxt;
  mul_op_e     r_op;
  mul_op_e     w_op_in;
  logic [63:0] r_multiplicand;
  logic [63:0] r_multiplier;
  logic [63:0] r_wb_data;
  logic [4:0]  r_rd;
  logic        r_mulw;
  logic [1:0]  r_mul_signed;
  logic [63:0] w_sel_data;
  logic        w_accept;
  logic        w_capture;
  logic        w_bypass;

  assign w_op_in   = decode_op(in_op);
  // Flush outranks a same-cycle request, so nothing is accepted under flush
  assign w_accept  = (r_state == ST_IDLE) && in_valid && !flush;
  // The unit's out_valid is a single-cycle pulse; only a waiting op takes it
  assign w_capture = (r_state == ST_WAIT) && mul_out_valid && !flush;

`ifdef MUL_ISSUE_CTRL_ZERO_BYPASS_EN
  // A zero operand makes the product zero; MULW only looks at the low words
  assign w_bypass = (w_op_in == OP_MULW) ?
                    ((in_src1[31:0] == 32'd0) || (in_src2[31:0] == 32'd0)) :
                    ((in_src1 == 64'd0) || (in_src2 == 64'd0));
`else
  assign w_bypass = 1'b0;
`endif

  mul_result_sel u_result_sel (
    .op        (r_op),
    .result_hi (result_hi),
    .result_lo (result_lo),
    .data      (w_sel_data)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; flush returns to IDLE from anywhere
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (in_valid)      w_state_nxt = w_bypass ? ST_DONE : ST_ISSUE;
        ST_ISSUE: if (mul_out_ready) w_state_nxt = ST_WAIT;
        ST_WAIT:  if (mul_out_valid) w_state_nxt = ST_DONE;
        ST_DONE:  if (wb_ready)      w_state_nxt = ST_IDLE;
        default:                     w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Operand/destination latch on accept, result capture on the unit pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op           <= OP_MUL;
      r_multiplicand <= '0;
      r_multiplier   <= '0;
      r_rd           <= '0;
      r_mulw         <= 1'b0;
      r_mul_signed   <= c_MS_UU;
      r_wb_data      <= '0;
    end else begin
      if (w_accept) begin
        r_op           <= w_op_in;
        r_multiplicand <= in_src1;
        r_multiplier   <= in_src2;
        r_rd           <= in_rd;
        r_mulw         <= (w_op_in == OP_MULW);
        r_mul_signed   <= signed_code(w_op_in);
        if (w_bypass) r_wb_data <= '0;
      end
      if (w_capture) r_wb_data <= w_sel_data;
    end
  end

  assign in_ready     = (r_state == ST_IDLE);
  assign busy         = (r_state != ST_IDLE);
  assign mul_valid    = (r_state == ST_ISSUE);
  assign wb_valid     = (r_state == ST_DONE);
  assign multiplicand = r_multiplicand;
  assign multiplier   = r_multiplier;
  assign mulw         = r_mulw;
  assign mul_signed   = r_mul_signed;
  assign wb_data      = r_wb_data;
  assign wb_rd        = r_rd;

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_issue_ctrl
// Description : Self-checking bench for mul_issue_ctrl with a behavioural
//               multiplier unit (8-cycle result pulse) and a transaction-level
//               reference model compared every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_issue_ctrl;

`ifdef MUL_ISSUE_CTRL_ZERO_BYPASS_EN
  localparam bit BYP_EN = 1'b1;
`else
  localparam bit BYP_EN = 1'b0;
`endif
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready, flush;
  logic [2:0]  in_op;
  logic [63:0] in_src1, in_src2;
  logic [4:0]  in_rd;
  logic        mul_valid, mulw, mul_out_ready, mul_out_valid;
  logic [1:0]  mul_signed;
  logic [63:0] multiplicand, multiplier, result_hi, result_lo;
  logic        wb_valid, wb_ready, busy;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mul_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd),
    .flush(flush),
    .mul_valid(mul_valid), .mulw(mulw), .mul_signed(mul_signed),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .mul_out_ready(mul_out_ready), .mul_out_valid(mul_out_valid),
    .result_hi(result_hi), .result_lo(result_lo),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
    .wb_rd(wb_rd), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural multiplier unit ----------------
  int          u_cnt;
  logic        u_ov;
  logic [63:0] u_hi, u_lo;
  logic        spur;

  function automatic logic [127:0] unit_mul(input logic [63:0] a, input logic [63:0] b,
                                            input logic [1:0] ms);
    logic [127:0] ea, eb;
    ea = {{64{a[63] & ms[1]}}, a};
    eb = {{64{b[63] & ms[0]}}, b};
    return ea * eb;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      u_cnt <= 0; u_ov <= 1'b0; u_hi <= '0; u_lo <= '0;
    end else if (flush) begin
      u_cnt <= 0; u_ov <= 1'b0;
    end else begin
      u_ov <= 1'b0;
      if (mul_valid && mul_out_ready) begin
        u_cnt <= 7;
        {u_hi, u_lo} <= unit_mul(multiplicand, multiplier, mul_signed);
      end else if (u_cnt != 0) begin
        u_cnt <= u_cnt - 1;
        if (u_cnt == 1) u_ov <= 1'b1;
      end
    end
  end

  // spur injects a stray result pulse carrying garbage
  assign mul_out_valid = u_ov | spur;
  assign result_hi     = spur ? 64'hBAD0_BAD0_BAD0_BAD0 : u_hi;
  assign result_lo     = spur ? 64'h0BAD_0BAD_0BAD_0BAD : u_lo;

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
    logic [127:0] p;
    case (op)
      3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
      3'd2: begin p = {{64{a[63]}}, a} * {64'd0, b};       return p[127:64]; end
      3'd3: begin p = {64'd0, a} * {64'd0, b};             return p[127:64]; end
      3'd4: begin p = {64'd0, a} * {64'd0, b};             return {{32{p[31]}}, p[31:0]}; end
      default: begin p = {64'd0, a} * {64'd0, b};          return p[63:0]; end
    endcase
  endfunction

  function automatic logic [1:0] ref_ms(input logic [2:0] op);
    if (op == 3'd2) return 2'b10;
    if (op == 3'd3) return 2'b00;
    return 2'b11;
  endfunction

  function automatic bit zero_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op == 3'd4) return (a[31:0] == 32'd0) || (b[31:0] == 32'd0);
    return (a == 64'd0) || (b == 64'd0);
  endfunction

  // One op in flight; m_age = cycles since the accepting edge
  bit          m_active = 1'b0;
  bit          m_byp = 1'b0;
  int          m_age = 0;
  logic [2:0]  m_op = '0;
  logic [63:0] m_a = '0, m_b = '0, m_res = '0;
  logic [4:0]  m_rd = '0;
  logic        e_wbv, e_mv, e_hold;

  assign e_wbv  = m_active && (m_age >= (m_byp ? 1 : 10));
  assign e_mv   = m_active && !m_byp && (m_age == 1);
  assign e_hold = m_active && !m_byp && (m_age <= 9);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
    end else if (flush) begin
      m_active <= 1'b0;
    end else if (!m_active) begin
      if (in_valid) begin
        m_active <= 1'b1;
        m_age    <= 1;
        m_op     <= in_op;
        m_a      <= in_src1;
        m_b      <= in_src2;
        m_rd     <= in_rd;
        m_res    <= ref_result(in_op, in_src1, in_src2);
        m_byp    <= BYP_EN && zero_op(in_op, in_src1, in_src2);
      end
    end else if (e_wbv && wb_ready) begin
      m_active <= 1'b0;
    end else begin
      m_age <= m_age + 1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    chk("in_ready", {63'd0, in_ready}, {63'd0, !m_active});
    chk("busy", {63'd0, busy}, {63'd0, m_active});
    chk("mul_valid", {63'd0, mul_valid}, {63'd0, e_mv});
    chk("wb_valid", {63'd0, wb_valid}, {63'd0, e_wbv});
    if (e_hold) begin
      chk("multiplicand", multiplicand, m_a);
      chk("multiplier", multiplier, m_b);
      chk("mul_signed", {62'd0, mul_signed}, {62'd0, ref_ms(m_op)});
      chk("mulw", {63'd0, mulw}, {63'd0, m_op == 3'd4});
    end
    if (e_wbv) begin
      chk("wb_data", wb_data, m_res);
      chk("wb_rd", {59'd0, wb_rd}, {59'd0, m_rd});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] rd, input logic [63:0] exp_data, input int exp_lat,
                        input bit exp_mv, input logic [1:0] exp_ms, input bit exp_w,
                        input int hold);
    int lat = 0;
    bit got_wb = 1'b0;
    bit mv_seen = 1'b0;
    logic [1:0] ms_seen = 2'b01;
    logic w_seen = 1'b0;
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_rd = rd;
    wb_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_op = 3'd3; in_src1 = ~a; in_src2 = ~b; in_rd = ~rd;
    while (!got_wb && lat < 40) begin
      @(negedge clk); lat++;
      if (mul_valid) begin mv_seen = 1'b1; ms_seen = mul_signed; w_seen = mulw; end
      if (wb_valid) got_wb = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("op_wb_seen", {63'd0, got_wb}, 64'd1);
    chk("op_latency", 64'(lat), 64'(exp_lat));
    chk("op_wb_data", wb_data, exp_data);
    chk("op_wb_rd", {59'd0, wb_rd}, {59'd0, rd});
    chk("op_mul_valid_seen", {63'd0, mv_seen}, {63'd0, exp_mv});
    if (exp_mv) begin
      chk("op_mul_signed", {62'd0, ms_seen}, {62'd0, exp_ms});
      chk("op_mulw", {63'd0, w_seen}, {63'd0, exp_w});
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      spur = (i == 2);
      @(negedge clk);
      chk("hold_wb_valid", {63'd0, wb_valid}, 64'd1);
      chk("hold_wb_data", wb_data, exp_data);
      chk("hold_wb_rd", {59'd0, wb_rd}, {59'd0, rd});
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    spur = 1'b0;
    wb_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_after_wb", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 1'b0; in_op = '0; in_src1 = '0; in_src2 = '0; in_rd = '0;
    flush = 1'b0; wb_ready = 1'b1; spur = 1'b0; mul_out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mul_valid", {63'd0, mul_valid}, 64'd0);
    chk("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_mulw", {63'd0, mulw}, 64'd0);
    chk("rst_mul_signed", {62'd0, mul_signed}, 64'd0);
    chk("rst_multiplicand", multiplicand, 64'd0);
    chk("rst_multiplier", multiplier, 64'd0);
    chk("rst_wb_data", wb_data, 64'd0);
    chk("rst_wb_rd", {59'd0, wb_rd}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    run_op(3'd0, 64'd3, 64'd5, 5'd1, 64'd15, 10, 1'b1, 2'b11, 1'b0, 0);
    run_op(3'd3, ALL1, ALL1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFE, 10, 1'b1, 2'b00, 1'b0, 0);
    run_op(3'd1, ALL1, ALL1, 5'd3, 64'd0, 10, 1'b1, 2'b11, 1'b0, 0);
    run_op(3'd2, ALL1, 64'd2, 5'd4, ALL1, 10, 1'b1, 2'b10, 1'b0, 0);
    run_op(3'd4, 64'h4000_0000, 64'd2, 5'd5, 64'hFFFF_FFFF_8000_0000, 10, 1'b1, 2'b11, 1'b1, 0);
    run_op(3'd6, 64'h1234, 64'h10, 5'd6, 64'h12340, 10, 1'b1, 2'b11, 1'b0, 0);

    // Flush in the 4th WAIT cycle, with a competing request in the same cycle
    in_valid = 1'b1; in_op = 3'd0; in_src1 = 64'd11; in_src2 = 64'd13; in_rd = 5'd12;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("pre_flush_busy", {63'd0, busy}, 64'd1);
    flush = 1'b1; in_valid = 1'b1; in_src1 = 64'd1; in_src2 = 64'd1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_in_ready", {63'd0, in_ready}, 64'd1);
    chk("flush_wb_valid", {63'd0, wb_valid}, 64'd0);
    repeat (12) @(posedge clk); #1;
    run_op(3'd0, 64'd7, 64'd6, 5'd7, 64'd42, 10, 1'b1, 2'b11, 1'b0, 0);

    // Writeback backpressure with a stray unit pulse while held
    run_op(3'd0, 64'd100, 64'd3, 5'd9, 64'd300, 10, 1'b1, 2'b11, 1'b0, 5);

    // Stray unit pulse while idle
    spur = 1'b1;
    @(posedge clk); #1 spur = 1'b0;
    @(negedge clk);
    chk("spur_idle_busy", {63'd0, busy}, 64'd0);
    @(posedge clk); #1;

    // Zero operand: bypassed when enabled, otherwise through the unit
    run_op(3'd0, 64'd0, 64'd9, 5'd10, 64'd0, BYP_EN ? 1 : 10, !BYP_EN, 2'b11, 1'b0, 0);

    // Reset in the middle of an op
    in_valid = 1'b1; in_op = 3'd1; in_src1 = 64'd21; in_src2 = 64'd22; in_rd = 5'd21;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_mul_valid", {63'd0, mul_valid}, 64'd0);
    chk("midrst_multiplicand", multiplicand, 64'd0);
    chk("midrst_multiplier", multiplier, 64'd0);
    chk("midrst_mul_signed", {62'd0, mul_signed}, 64'd0);
    chk("midrst_wb_data", wb_data, 64'd0);
    chk("midrst_wb_rd", {59'd0, wb_rd}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (14) @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
